keypad_scan: RTL and testbench
==============================

# keypad_scan

4x4 matrix keypad scanner: drives one-hot active-low column strobes, samples the active-low row returns, debounces, and emits one pulse per key press with a 4-bit key code. It is the input-side counterpart of the multiplexed seven-segment display driver: the display scans digits out, this block scans keys in. It feeds the timer's set-time path in place of the `s_hour`/`s_min` push buttons.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per column dwell (scan tick period). Must be ≥ 4.
- `DEB_CNT`, default 4: consecutive identical tick samples required to accept a press or a release. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `row`  in  4  keypad row returns. Active-low, pulled up externally, asynchronous to `clk`.
- `col`  out  4  column strobes. Active-low, exactly one bit low at all times.
- `key_code`  out  4  code of the last accepted key, `row_idx*4 + col_idx`. Held until the next accepted key.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_down`  out  1  high from acceptance until the release is accepted.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Tick generator: a counter runs 0..SCAN_DIV-1. The tick fires in the cycle the counter equals SCAN_DIV-1.
- Sample: the synchronized row value captured on a tick. It reflects the column driven since the previous tick.
- Sample classification:
  - idle: all ones.
  - single: exactly one zero.
  - multi: two or more zeros.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN, on each tick:
  - single sample: latch the row index into the candidate, clear the debounce count to 1, go to DEBOUNCE. The column does not advance.
  - idle or multi sample: advance the column 0→1→2→3→0 (`col` = 1110, 1101, 1011, 0111).
- DEBOUNCE (column frozen), on each tick:
  - sample single and equal to the candidate: increment the count. On reaching DEB_CNT, set `key_code`, pulse `key_valid`, set `key_down`, go to HELD.
  - any other sample: return to SCAN and advance the column.
- HELD (column frozen), on each tick:
  - idle sample: go to RELEASE, count = 1.
  - any non-idle sample (including a second key): no action.
- RELEASE, on each tick:
  - idle sample: increment the count. On reaching DEB_CNT, clear `key_down`, go to SCAN and advance the column.
  - any non-idle sample: return to HELD, no new `key_valid`.
- Only one key is reported per press. Keys pressed in other columns while HELD are ignored until release.
- Reset mid-operation returns every register to its reset value on the next edge. No pulse is emitted.

## Timing
- Reset values:
  - `col` = 4'b1110
  - `key_code` = 0
  - `key_valid` = 0
  - `key_down` = 0
  - state = SCAN, column index = 0, tick counter = 0, synchronizer = 4'b1111.
- `key_valid` rises in the cycle after the tick that completes DEB_CNT matching samples, and lasts exactly one cycle.
- `key_code` and `key_down` update in the same cycle `key_valid` rises.
- `key_down` falls in the cycle after the tick completing DEB_CNT idle samples.
- `col` changes only in the cycle after a tick.
- Press-to-pulse latency, worst case: (3 + DEB_CNT) × SCAN_DIV + 3 cycles. This covers up to 3 column advances, DEB_CNT samples, and the synchronizer.

## Structure
- Shared package: state enum (SCAN, DEBOUNCE, HELD, RELEASE), column pattern constants, and the `row_idx*4+col_idx` code function.
- One natural sub-module, `keypad_tick_gen`: SCAN_DIV counter producing the tick.
- The synchronizer and FSM stay in the top.

## Test plan
All scenarios use SCAN_DIV=4, DEB_CNT=3.

- Reset: assert `rst` 2 cycles with `row`=1111 → `col`=1110, `key_valid`=0, `key_down`=0, `key_code`=0. The column walks 1101, 1011, 0111, 1110 on successive ticks, 4 cycles apart.
- Clean press: when `col`=1011 drive `row`=1101 for 40 cycles, then release → one `key_valid` pulse with `key_code`=6. `key_down` is high until 3 idle ticks after release, then scanning resumes at `col`=0111.
- Bounce: toggle `row` between 1110 and 1111 every tick while `col`=1110 → no `key_valid`, and the column keeps advancing. A stable press afterwards yields `key_code`=0.
- Multi-row: drive `row`=1100 on `col`=0111 for 40 cycles → no `key_valid`, and the scan continues.
- Release glitch: hold key 15 (`row`=0111, `col`=0111), release for 1 tick, re-press for 2 ticks, then release for good → exactly one `key_valid`. `key_down` stays high through the glitch.
- Reset mid-DEBOUNCE: assert `rst` after 2 matching samples → no `key_valid`, all outputs at reset values, and `col`=1110 the cycle after reset.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, sample classes,
// column strobe patterns and small decode helpers.
// Pure package; no ports, no timing, no flow control.
package keypad_scan_pkg;

    // Scanner FSM: walk columns, confirm a press, hold it, confirm a release.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // What one tick sample of the row returns looks like.
    typedef enum logic [1:0] {
        SMP_IDLE   = 2'd0,  // no row pulled low
        SMP_SINGLE = 2'd1,  // exactly one row low
        SMP_MULTI  = 2'd2   // two or more rows low (ghosting / multi-press)
    } smp_class_t;

    // Active-low one-hot column strobes, indexed by column.
    localparam logic [3:0] COL_PAT_0 = 4'b1110;
    localparam logic [3:0] COL_PAT_1 = 4'b1101;
    localparam logic [3:0] COL_PAT_2 = 4'b1011;
    localparam logic [3:0] COL_PAT_3 = 4'b0111;

    // Row returns with nothing pressed (external pull-ups).
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = COL_PAT_0;
            2'd1:    pat = COL_PAT_1;
            2'd2:    pat = COL_PAT_2;
            default: pat = COL_PAT_3;
        endcase
        return pat;
    endfunction

    function automatic smp_class_t classify(input logic [3:0] smp);
        logic [2:0] zeros;
        smp_class_t cls;
        zeros = 3'd0;
        for (int i = 0; i < 4; i++) begin
            zeros = zeros + {2'b00, ~smp[i]};
        end
        if (zeros == 3'd0) begin
            cls = SMP_IDLE;
        end else if (zeros == 3'd1) begin
            cls = SMP_SINGLE;
        end else begin
            cls = SMP_MULTI;
        end
        return cls;
    endfunction

    // Index of the lowest row that is pulled low. Only meaningful for a
    // single-zero sample; returns 0 for an idle sample.
    function automatic logic [1:0] row_index(input logic [3:0] smp);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!smp[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Key code = row_idx*4 + col_idx, which is just the concatenation.
    function automatic logic [3:0] key_code_of(input logic [1:0] row_idx,
                                               input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick generator: free-running 0..SCAN_DIV-1 counter, tick in the last count.
// Latency: tick_o is combinational from the counter; first tick SCAN_DIV-1 cycles after reset.
// Backpressure: none; the tick always fires on schedule.
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset (counter back to 0)
//   tick_o  high for one cycle out of every SCAN_DIV
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobes out, debounced key press pulses in.
// Latency: press to key_valid at most (3+DEB_CNT)*SCAN_DIV+3 cycles; release likewise.
// Backpressure: none; key_valid is a single-cycle pulse the consumer must catch.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row        active-low row returns, asynchronous to clk
//   col        active-low one-hot column strobe (registered)
//   key_code   row_idx*4+col_idx of the last accepted key, held until the next
//   key_valid  one-cycle pulse on press acceptance
//   key_down   high from press acceptance until release acceptance
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    // Debounce counter only ever needs to hold 1..DEB_CNT-1.
    localparam int CNTW = $clog2(DEB_CNT + 1);
    localparam logic [CNTW-1:0] DEB_LAST = CNTW'(DEB_CNT - 1);
    localparam logic [CNTW-1:0] DEB_ONE  = CNTW'(1);

    // ------------------------------------------------------------------
    // Row synchronizer: row is asynchronous, so nothing downstream may
    // look at it before two flops.
    // ------------------------------------------------------------------
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= ROW_IDLE;
            row_sync_q <= ROW_IDLE;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Scan tick
    // ------------------------------------------------------------------
    logic tick;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    // ------------------------------------------------------------------
    // Sample decode. The synchronized row value seen on a tick belongs to
    // the column that has been driven since the previous tick.
    // ------------------------------------------------------------------
    smp_class_t smp_class;
    logic [1:0] smp_row;
    logic       smp_idle;
    logic       smp_single;

    always_comb begin
        smp_class  = classify(row_sync_q);
        smp_row    = row_index(row_sync_q);
        smp_idle   = (smp_class == SMP_IDLE);
        smp_single = (smp_class == SMP_SINGLE);
    end

    // ------------------------------------------------------------------
    // Scanner FSM with registered outputs
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      col_idx_d;
    logic [3:0]      col_q;
    logic [1:0]      cand_q;
    logic [CNTW-1:0] cnt_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_down_q;

    // Next column in the walk 0->1->2->3->0 (2-bit wrap does the modulo).
    assign col_idx_d = col_idx_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            col_q       <= COL_PAT_0;
            cand_q      <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (smp_single) begin
                            // Freeze the column on this candidate and start
                            // counting matching samples.
                            cand_q  <= smp_row;
                            cnt_q   <= DEB_ONE;
                            state_q <= ST_DEBOUNCE;
                        end else begin
                            // Idle or ambiguous multi-row sample: keep walking.
                            col_idx_q <= col_idx_d;
                            col_q     <= col_pattern(col_idx_d);
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (smp_single && (smp_row == cand_q)) begin
                            if (cnt_q == DEB_LAST) begin
                                key_code_q  <= key_code_of(cand_q, col_idx_q);
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                                state_q     <= ST_HELD;
                            end else begin
                                cnt_q <= cnt_q + DEB_ONE;
                            end
                        end else begin
                            // Bounce or change of mind: give up on this
                            // candidate and move on rather than re-trying the
                            // same column forever.
                            state_q   <= ST_SCAN;
                            col_idx_q <= col_idx_d;
                            col_q     <= col_pattern(col_idx_d);
                        end
                    end

                    ST_HELD: begin
                        // Other keys are ignored while one is held; only a
                        // clean idle sample can start the release.
                        if (smp_idle) begin
                            cnt_q   <= DEB_ONE;
                            state_q <= ST_RELEASE;
                        end
                    end

                    ST_RELEASE: begin
                        if (smp_idle) begin
                            if (cnt_q == DEB_LAST) begin
                                key_down_q <= 1'b0;
                                state_q    <= ST_SCAN;
                                col_idx_q  <= col_idx_d;
                                col_q      <= col_pattern(col_idx_d);
                            end else begin
                                cnt_q <= cnt_q + DEB_ONE;
                            end
                        end else begin
                            // Release glitch: still the same press, no new pulse.
                            state_q <= ST_HELD;
                        end
                    end

                    default: begin
                        state_q <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [3:0]  row_drv;
    logic [3:0]  kp_row;
    logic [15:0] pressed;
    logic        use_kp;

    int checks;
    int errors;
    int pulses;
    int model_pulses;

    keypad_scan #(
        .SCAN_DIV (SD),
        .DEB_CNT  (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key at (r,c) pulls row r low while column c is strobed.
    always_comb begin
        kp_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (col[c] == 1'b0)) begin
                    kp_row[r] = 1'b0;
                end
            end
        end
    end

    assign row = use_kp ? kp_row : row_drv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: row samples seen two cycles late, one sample every
    // SD cycles since reset; tracks the current column, a pending candidate
    // with its run of identical samples, and the run of idle samples while held.
    // ------------------------------------------------------------------
    bit         model_ok;
    int         m_n;
    logic [3:0] m_hist [2];   // [0] newest synchronizer stage, [1] the one the logic sees
    int         m_col;
    int         m_cand;       // -1 = no candidate
    int         m_run;
    int         m_idle_run;
    bit         m_down;
    bit         m_valid;
    int         m_code;

    always @(posedge clk) begin
        if (rst) begin
            model_ok   = 1'b1;
            m_n        = 0;
            m_hist[0]  = 4'hF;
            m_hist[1]  = 4'hF;
            m_col      = 0;
            m_cand     = -1;
            m_run      = 0;
            m_idle_run = 0;
            m_down     = 1'b0;
            m_valid    = 1'b0;
            m_code     = 0;
        end else if (model_ok) begin
            m_valid = 1'b0;
            if ((m_n % SD) == SD - 1) begin
                logic [3:0] s;
                int zeros;
                int ridx;
                s = m_hist[1];
                zeros = 0;
                ridx = 0;
                for (int i = 3; i >= 0; i--) begin
                    if (!s[i]) begin
                        zeros++;
                        ridx = i;
                    end
                end
                if (m_down) begin
                    if (zeros == 0) begin
                        m_idle_run++;
                        if (m_idle_run == DEB) begin
                            m_down = 1'b0;
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_idle_run = 0;
                    end
                end else if (m_cand < 0) begin
                    if (zeros == 1) begin
                        m_cand = ridx;
                        m_run = 1;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end else begin
                    if (zeros == 1 && ridx == m_cand) begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_code = m_cand * 4 + m_col;
                            m_valid = 1'b1;
                            m_down = 1'b1;
                            m_idle_run = 0;
                            m_cand = -1;
                            model_pulses++;
                        end
                    end else begin
                        m_cand = -1;
                        m_col = (m_col + 1) % 4;
                    end
                end
            end
            m_n++;
            m_hist[1] = m_hist[0];
            m_hist[0] = row;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
        if (model_ok) begin
            logic [3:0] exp_col;
            exp_col = 4'b1111 ^ (4'b0001 << m_col);
            check("col", {28'd0, col}, {28'd0, exp_col});
            check("key_code", {28'd0, key_code}, 32'(m_code));
            check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
            check("key_down", {31'd0, key_down}, {31'd0, m_down});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_col(input logic [3:0] pat);
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (col !== pat && k < 64);
        if (col !== pat) check("wait_col", {28'd0, col}, {28'd0, pat});
    endtask

    task automatic wait_release();
        int k;
        k = 0;
        while (key_down !== 1'b0 && k < 64) begin
            step(1);
            k++;
        end
        if (key_down !== 1'b0) check("wait_release", {31'd0, key_down}, 32'd0);
    endtask

    initial begin
        int p0;
        int changes;
        logic [3:0] prev;
        bit kd_low_seen;

        checks = 0; errors = 0; pulses = 0; model_pulses = 0;
        model_ok = 1'b0;
        rst = 1'b1; row_drv = 4'hF; use_kp = 1'b0; pressed = '0;

        // Reset and column walk
        step(2);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_down", {31'd0, key_down}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k == 3)  check("walk3", {28'd0, col}, 32'hE);
            if (k == 4)  check("walk4", {28'd0, col}, 32'hD);
            if (k == 7)  check("walk7", {28'd0, col}, 32'hD);
            if (k == 8)  check("walk8", {28'd0, col}, 32'hB);
            if (k == 12) check("walk12", {28'd0, col}, 32'h7);
            if (k == 16) check("walk16", {28'd0, col}, 32'hE);
        end

        // Clean press of key 6
        wait_col(4'b1011);
        p0 = pulses;
        row_drv = 4'b1101;
        step(40);
        check("press_pulses", 32'(pulses - p0), 32'd1);
        check("press_code", {28'd0, key_code}, 32'd6);
        check("press_down", {31'd0, key_down}, 32'd1);
        row_drv = 4'hF;
        wait_release();
        check("resume_col", {28'd0, col}, 32'h7);

        // Bounce on column 0
        wait_col(4'b1110);
        p0 = pulses; changes = 0; prev = col;
        for (int i = 0; i < 6; i++) begin
            row_drv = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            for (int j = 0; j < SD; j++) begin
                step(1);
                if (col !== prev) changes++;
                prev = col;
            end
        end
        row_drv = 4'hF;
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check("bounce_advance", {31'd0, changes >= 2}, 32'd1);
        wait_col(4'b1110);
        row_drv = 4'b1110;
        step(40);
        check("bounce_then_press", 32'(pulses - p0), 32'd1);
        check("bounce_code", {28'd0, key_code}, 32'd0);
        row_drv = 4'hF;
        wait_release();

        // Multi-row press
        wait_col(4'b0111);
        p0 = pulses; changes = 0; prev = col;
        row_drv = 4'b1100;
        for (int j = 0; j < 40; j++) begin
            step(1);
            if (col !== prev) changes++;
            prev = col;
        end
        row_drv = 4'hF;
        check("multi_pulses", 32'(pulses - p0), 32'd0);
        check("multi_advance", {31'd0, changes >= 8}, 32'd1);
        step(8);

        // Release glitch on key 15
        wait_col(4'b0111);
        p0 = pulses;
        row_drv = 4'b0111;
        step(40);
        check("glitch_code", {28'd0, key_code}, 32'd15);
        kd_low_seen = 1'b0;
        row_drv = 4'hF;
        for (int j = 0; j < SD; j++) begin
            step(1);
            if (key_down !== 1'b1) kd_low_seen = 1'b1;
        end
        row_drv = 4'b0111;
        for (int j = 0; j < 2 * SD; j++) begin
            step(1);
            if (key_down !== 1'b1) kd_low_seen = 1'b1;
        end
        check("glitch_down_held", {31'd0, kd_low_seen}, 32'd0);
        row_drv = 4'hF;
        wait_release();
        check("glitch_pulses", 32'(pulses - p0), 32'd1);

        // Reset in the middle of debouncing
        wait_col(4'b1101);
        wait_col(4'b1110);
        p0 = pulses;
        row_drv = 4'b1110;
        step(9);
        rst = 1'b1;
        step(2);
        row_drv = 4'hF;
        check("midrst_col", {28'd0, col}, 32'hE);
        check("midrst_code", {28'd0, key_code}, 32'd0);
        check("midrst_down", {31'd0, key_down}, 32'd0);
        rst = 1'b0;
        step(1);
        check("midrst_col_after", {28'd0, col}, 32'hE);
        step(20);
        check("midrst_pulses", 32'(pulses - p0), 32'd0);

        // Randomized keypad activity
        use_kp = 1'b1;
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) pressed = 16'(1 << $urandom_range(0, 15));
            else if (r < 9) pressed = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
            else pressed = '0;
            if ($urandom_range(0, 3) == 0) begin
                logic [15:0] keep;
                keep = pressed;
                for (int b = 0; b < 4; b++) begin
                    pressed = (b % 2 == 0) ? 16'h0 : keep;
                    step($urandom_range(1, 6));
                end
                pressed = keep;
            end
            step($urandom_range(0, 60));
            pressed = '0;
            step($urandom_range(0, 40));
        end
        step(40);
        use_kp = 1'b0;
        check("pulse_total", 32'(pulses), 32'(model_pulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
